// File: rtl/line_proc_wrapper.sv
// Line-based pixel processing stage: queued line kicks, 2-stage pixel pipeline (pass/invert/gray/threshold).
// Optional macro LINE_STATS_EN adds LINE_COUNT and BUSY outputs.
`timescale 1ns/1ps
module line_proc_wrapper #(
  parameter int unsigned WIDTH      = 1600,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned PEND_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        READ_LINE_DONE,
  output logic        IN_DE,
  input  logic [31:0] IN_DATA,
  input  logic [1:0]  MODE,
  input  logic [7:0]  THRESH,
  output logic        OUT_DE,
  output logic [31:0] OUT_DATA,
  output logic        WRITE_LINE_DONE,
  output logic        OVERFLOW
`ifdef LINE_STATS_EN
  ,
  output logic [15:0] LINE_COUNT,
  output logic        BUSY
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int unsigned PEND_W   = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend;
  logic [1:0]        mode_q;
  logic [7:0]        thresh_q;

  logic              s1_valid;
  logic              s1_last;
  logic [31:0]       s1_data;
  logic [31:0]       s2_result;
  logic [7:0]        luma;
  logic [7:0]        bin;

  assign IN_DE = (state == S_RUN);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; mode_q relatching in GAP cannot disturb the
  // previous line's last pixel still being computed in S2 at that same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pend     <= '0;
      mode_q   <= 2'd0;
      thresh_q <= 8'd0;
      OVERFLOW <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (READ_LINE_DONE) begin
            state    <= S_RUN;
            cnt      <= '0;
            mode_q   <= MODE;
            thresh_q <= THRESH;
          end
        end
        S_RUN: begin
          if (cnt == LAST_IDX) begin
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (READ_LINE_DONE) begin
            if (pend == PEND_MAX) OVERFLOW <= 1'b1;
            else                  pend     <= pend + 1'b1;
          end
        end
        S_GAP: begin
          if (pend != '0) begin
            state    <= S_RUN;
            mode_q   <= MODE;
            thresh_q <= THRESH;
            // A kick while full is dropped; otherwise it cancels the decrement.
            if (READ_LINE_DONE && pend == PEND_MAX) OVERFLOW <= 1'b1;
            if (!READ_LINE_DONE || pend == PEND_MAX) pend <= pend - 1'b1;
          end else if (READ_LINE_DONE) begin
            state    <= S_RUN;
            mode_q   <= MODE;
            thresh_q <= THRESH;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 control: valid is reset so an abandoned line leaves no ghost pixel.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) s1_valid <= 1'b0;
    else        s1_valid <= IN_DE;
  end

  // NOTE: pixel and tag registers carry no reset; they are only ever consumed
  // when s1_valid is set, so their power-up contents are never observed.
  always_ff @(posedge CLK) begin
    s1_data <= IN_DATA;
    s1_last <= (cnt == LAST_IDX);
  end

  // Luma: 16-bit weighted sum, truncated to its upper byte.
  assign luma = 8'(({8'd0, s1_data[23:16]} * 16'd77
                  + {8'd0, s1_data[15:8]}  * 16'd150
                  + {8'd0, s1_data[7:0]}   * 16'd29) >> 8);
  assign bin  = (luma >= thresh_q) ? 8'hFF : 8'h00;

  // NOTE: s2_result is given a value on every path (default arm) so no latch
  // is inferred.
  always_comb begin
    case (mode_q)
      2'd0:    s2_result = s1_data;
      2'd1:    s2_result = {s1_data[31:24], ~s1_data[23:0]};
      2'd2:    s2_result = {s1_data[31:24], luma, luma, luma};
      default: s2_result = {s1_data[31:24], bin, bin, bin};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_DE          <= 1'b0;
      OUT_DATA        <= 32'd0;
      WRITE_LINE_DONE <= 1'b0;
    end else begin
      OUT_DE          <= s1_valid;
      WRITE_LINE_DONE <= s1_valid & s1_last;
      if (s1_valid) OUT_DATA <= s2_result;
    end
  end

`ifdef LINE_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)               LINE_COUNT <= 16'd0;
    else if (WRITE_LINE_DONE) LINE_COUNT <= LINE_COUNT + 16'd1;
  end

  assign BUSY = (state != S_IDLE) | s1_valid | OUT_DE;
`endif

endmodule

// File: tb/tb_line_proc_wrapper.sv
// Scoreboard bench for line_proc_wrapper (WIDTH=8, PEND_DEPTH=2): directed lines, kick queue, reset mid-line.
`timescale 1ns/1ps
module tb_line_proc_wrapper;
  localparam int W = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        READ_LINE_DONE = 1'b0;
  logic        IN_DE;
  logic [31:0] IN_DATA = 32'd0;
  logic [1:0]  MODE = 2'd0;
  logic [7:0]  THRESH = 8'd0;
  logic        OUT_DE;
  logic [31:0] OUT_DATA;
  logic        WRITE_LINE_DONE;
  logic        OVERFLOW;
`ifdef LINE_STATS_EN
  logic [15:0] LINE_COUNT;
  logic        BUSY;
`endif

  line_proc_wrapper #(.WIDTH(W), .CNT_W(12), .PEND_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .READ_LINE_DONE(READ_LINE_DONE),
    .IN_DE(IN_DE), .IN_DATA(IN_DATA), .MODE(MODE), .THRESH(THRESH),
    .OUT_DE(OUT_DE), .OUT_DATA(OUT_DATA), .WRITE_LINE_DONE(WRITE_LINE_DONE),
    .OVERFLOW(OVERFLOW)
`ifdef LINE_STATS_EN
    , .LINE_COUNT(LINE_COUNT), .BUSY(BUSY)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_fail = 0;
  int wld_cnt = 0;
  int de_cycles = 0;
  logic [32:0] exp_q[$];   // {last, data}
  logic [31:0] src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input logic [7:0] th, input logic [31:0] p);
    int y;
    logic [7:0] y8, v;
    y  = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    y8 = y[7:0];
    v  = (y8 >= th) ? 8'hFF : 8'h00;
    case (m)
      2'd0:    return p;
      2'd1:    return {p[31:24], ~p[23:0]};
      2'd2:    return {p[31:24], y8, y8, y8};
      default: return {p[31:24], v, v, v};
    endcase
  endfunction

  task automatic load_line(input logic [1:0] m, input logic [7:0] th, input logic [31:0] base, input logic [31:0] step);
    logic [31:0] p;
    for (int i = 0; i < W; i++) begin
      p = base + step * i;
      src_q.push_back(p);
      exp_q.push_back({(i == W - 1), model(m, th, p)});
    end
  endtask

  // Same pixel for the whole line, with a hand-computed expected value.
  task automatic load_const(input logic [31:0] pix, input logic [31:0] exp);
    for (int i = 0; i < W; i++) begin
      src_q.push_back(pix);
      exp_q.push_back({(i == W - 1), exp});
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IN_DE cycle.
  task automatic kick(input logic [1:0] m, input logic [7:0] th);
    MODE = m;
    THRESH = th;
    READ_LINE_DONE = 1'b1;
    @(negedge CLK);
    READ_LINE_DONE = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while ((exp_q.size() != 0 || IN_DE) && n < 300) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  // Source: present the next pixel for every cycle the DUT requests one.
  initial begin
    forever begin
      @(negedge CLK);
      if (IN_DE === 1'b1) begin
        de_cycles++;
        if (src_q.size() > 0) IN_DATA = src_q.pop_front();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      if (OUT_DE === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_de", OUT_DE, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", OUT_DATA, e[31:0]);
          check("wld_tag", WRITE_LINE_DONE, e[32]);
        end
        if (WRITE_LINE_DONE === 1'b1) wld_cnt++;
      end else if (WRITE_LINE_DONE !== 1'b0) begin
        check("wld_without_de", WRITE_LINE_DONE, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] pat, pat_exp;
    int wld0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_in_de", IN_DE, 0);
    check("rst_out_de", OUT_DE, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_wld", WRITE_LINE_DONE, 0);
    check("rst_overflow", OVERFLOW, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Pass-through, index pixels, latency
    load_line(2'd0, 8'd0, 32'd0, 32'd1);
    de_cycles = 0;
    MODE = 2'd0;
    READ_LINE_DONE = 1'b1;
    check("t1_in_de_kick_cycle", IN_DE, 0);
    @(negedge CLK);
    READ_LINE_DONE = 1'b0;
    check("t1_in_de_first", IN_DE, 1);
    check("t1_out_de_lat0", OUT_DE, 0);
    @(negedge CLK);
    check("t1_out_de_lat1", OUT_DE, 0);
    @(negedge CLK);
    check("t1_out_de_lat2", OUT_DE, 1);
    wait_idle();
    check("t1_in_de_cycles", de_cycles, W);
    check("t1_wld_count", wld_cnt, 1);

    // Directed arithmetic vectors
    load_const(32'h80FF8040, 32'h809E9E9E); kick(2'd2, 8'h00); wait_idle();
    load_const(32'h80FF8040, 32'h80007FBF); kick(2'd1, 8'h00); wait_idle();
    load_const(32'h00FF8040, 32'h00FFFFFF); kick(2'd3, 8'h9E); wait_idle();
    load_const(32'h00FF8040, 32'h00000000); kick(2'd3, 8'h9F); wait_idle();
    check("t2_wld_count", wld_cnt, 5);
    check("t2_overflow_clear", OVERFLOW, 0);

    // Queue: 4 kicks during line 1 -> 2 queued, 2 dropped
    wld0 = wld_cnt;
    load_line(2'd0, 8'd0, 32'h1000_0000, 32'h0001_0101);
    load_line(2'd0, 8'd0, 32'h2000_0000, 32'h0003_0507);
    load_line(2'd0, 8'd0, 32'h3000_0000, 32'h0102_0304);
    kick(2'd0, 8'd0);
    for (int i = 0; i < 27; i++) begin
      if (i > 0) @(negedge CLK);
      READ_LINE_DONE = (i == 1 || i == 3 || i == 5 || i == 7);
      pat[i] = IN_DE;
      pat_exp[i] = !(i == 8 || i == 17 || i == 26);
    end
    READ_LINE_DONE = 1'b0;
    check("t4_in_de_pattern", 32'(pat), 32'(pat_exp));
    wait_idle();
    check("t4_overflow", OVERFLOW, 1);
    check("t4_lines", wld_cnt - wld0, 3);

    // Kick in GAP with PEND=0, mode change mid-line
    wld0 = wld_cnt;
    load_line(2'd0, 8'd0, 32'h4433_2211, 32'h0011_2233);
    load_line(2'd1, 8'd0, 32'h55AA_0F0F, 32'h0102_0408);
    kick(2'd0, 8'd0);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 3) MODE = 2'd1;
      READ_LINE_DONE = (i == 8);
      pat[i] = IN_DE;
      pat_exp[i] = !(i == 8 || i == 17);
    end
    READ_LINE_DONE = 1'b0;
    check("t5_in_de_pattern", 32'(pat[17:0]), 32'(pat_exp[17:0]));
    wait_idle();
    check("t5_lines", wld_cnt - wld0, 2);

    // Reset at pixel 4: line abandoned
    load_line(2'd0, 8'd0, 32'h0000_0100, 32'd1);
    kick(2'd0, 8'd0);
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_rst_in_de", IN_DE, 0);
    check("t6_rst_out_de", OUT_DE, 0);
    check("t6_rst_out_data", OUT_DATA, 0);
    check("t6_rst_wld", WRITE_LINE_DONE, 0);
    check("t6_rst_overflow", OVERFLOW, 0);
    exp_q.delete();
    src_q.delete();
    wld0 = wld_cnt;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    check("t6_no_wld_after_rst", wld_cnt - wld0, 0);

    // Recovery: three threshold/gray lines after reset
    load_line(2'd3, 8'h80, 32'hFF10_2030, 32'h0011_1111);
    kick(2'd3, 8'h80);
`ifdef LINE_STATS_EN
    check("t7_busy_high", BUSY, 1);
`endif
    wait_idle();
    load_line(2'd2, 8'h00, 32'h0708_090A, 32'h0013_1715);
    kick(2'd2, 8'h00); wait_idle();
    load_line(2'd1, 8'h00, 32'hC0FF_0080, 32'h0101_0101);
    kick(2'd1, 8'h00); wait_idle();
    check("t7_lines", wld_cnt - wld0, 3);
`ifdef LINE_STATS_EN
    check("t7_line_count", LINE_COUNT, 3);
    check("t7_busy_low", BUSY, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
